somatorio_param: RTL and testbench

//  Parametrised successor of the summation state machine: accumulates QUANTIDADE signed samples of

---
 rtl/somatorio_pkg.sv | 29 ++
 rtl/somador_sat.sv | 35 +++
 rtl/somatorio_param.sv | 98 +++++++++
 tb/tb_somatorio_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/somatorio_pkg.sv
// rtl/somatorio_pkg.sv - state type, width-derived limits and sign-extension helpers for somatorio_param
package somatorio_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ACUMULA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   localparam int LARGURA_MAX = 64;

   // Largest positive value representable in a two's complement word of 'largura' bits
   function automatic logic signed [LARGURA_MAX-1:0] soma_max(input int largura);
      return (64'sd1 <<< (largura - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [LARGURA_MAX-1:0] soma_min(input int largura);
      return -(64'sd1 <<< (largura - 1));
   endfunction

   // Replicates bit largura-1 of v into every higher bit
   function automatic logic [LARGURA_MAX-1:0] sext(input logic [LARGURA_MAX-1:0] v,
                                                   input int largura);
      logic signed [LARGURA_MAX-1:0] t;
      t = $signed(v << (LARGURA_MAX - largura));
      return t >>> (LARGURA_MAX - largura);
   endfunction

endpackage

// File: rtl/somador_sat.sv
// rtl/somador_sat.sv - signed adder with overflow flag; clamps on overflow when SOMATORIO_SAT_EN is defined
module somador_sat
   import somatorio_pkg::*;
#(
   parameter int W = 6
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] resultado,
   output logic                ov
);

`ifdef SOMATORIO_SAT_EN
   localparam logic signed [W-1:0] SOMA_MAX = W'(soma_max(W));
   localparam logic signed [W-1:0] SOMA_MIN = W'(soma_min(W));
`endif

   logic signed [W-1:0] bruto;

   always_comb begin
      bruto = a + b;
      // Overflow only possible when both operands share a sign the result lost
      ov    = (a[W-1] == b[W-1]) && (bruto[W-1] != a[W-1]);
`ifdef SOMATORIO_SAT_EN
      if (ov) begin
         resultado = a[W-1] ? SOMA_MIN : SOMA_MAX;
      end else begin
         resultado = bruto;
      end
`else
      resultado = bruto;
`endif
   end

endmodule

// File: rtl/somatorio_param.sv
// rtl/somatorio_param.sv - accumulates quantidade signed samples over valid/ready; SOMATORIO_SAT_EN selects saturation
module somatorio_param
   import somatorio_pkg::*;
#(
   parameter int LARGURA      = 6,
   parameter int GUARDA       = 0,
   parameter int LARGURA_CONT = 6
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              inicio,
   input  logic        [LARGURA_CONT-1:0]    quantidade,
   input  logic signed [LARGURA-1:0]         valor,
   input  logic                              valor_valido,
   output logic                              valor_pronto,
   output logic                              ocupado,
   output logic                              pronto,
   output logic                              overflow,
   output logic signed [LARGURA+GUARDA-1:0]  soma,
   output logic        [LARGURA_CONT-1:0]    contador
);

   localparam int SW = LARGURA + GUARDA;

   estado_t            estado;
   estado_t            proximo;
   logic               aceita;
   logic               ov_soma;
   logic signed [SW-1:0] valor_ext;
   logic signed [SW-1:0] soma_nova;

   assign valor_ext = SW'(sext(64'(valor), LARGURA));
   assign aceita    = valor_valido & valor_pronto;

   somador_sat #(
      .W (SW)
   ) u_somador (
      .a         (soma),
      .b         (valor_ext),
      .resultado (soma_nova),
      .ov        (ov_soma)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         estado <= OCIOSO;
      end else begin
         estado <= proximo;
      end
   end

   always_comb begin
      proximo      = estado;
      valor_pronto = 1'b0;
      ocupado      = 1'b0;
      pronto       = 1'b0;
      case (estado)
         OCIOSO: begin
            if (inicio) begin
               proximo = (quantidade != '0) ? ACUMULA : FIM;
            end
         end
         ACUMULA: begin
            valor_pronto = 1'b1;
            ocupado      = 1'b1;
            if (valor_valido && (contador == LARGURA_CONT'(1))) begin
               proximo = FIM;
            end
         end
         FIM: begin
            ocupado = 1'b1;
            pronto  = 1'b1;
            proximo = OCIOSO;
         end
         default: begin
            proximo = OCIOSO;
         end
      endcase
   end

   // Results of the previous operation stay visible until the next inicio is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         soma     <= '0;
         overflow <= 1'b0;
         contador <= '0;
      end else if ((estado == OCIOSO) && inicio) begin
         soma     <= '0;
         overflow <= 1'b0;
         contador <= quantidade;
      end else if (aceita) begin
         soma     <= soma_nova;
         overflow <= overflow | ov_soma;
         contador <= contador - LARGURA_CONT'(1);
      end
   end

endmodule

// File: tb/tb_somatorio_param.sv
// tb/tb_somatorio_param.sv - randomized scoreboard bench for somatorio_param (honours SOMATORIO_SAT_EN)
module tb_somatorio_param;

   localparam int LARGURA      = 6;
   localparam int GUARDA       = 0;
   localparam int LARGURA_CONT = 6;
   localparam int SW           = LARGURA + GUARDA;
   localparam int SMAX         = (1 << (SW - 1)) - 1;
   localparam int SMIN         = -(1 << (SW - 1));
   localparam int MODULO       = 1 << SW;

   logic                           clk = 1'b0;
   logic                           reset = 1'b1;
   logic                           inicio = 1'b0;
   logic        [LARGURA_CONT-1:0] quantidade = '0;
   logic signed [LARGURA-1:0]      valor = '0;
   logic                           valor_valido = 1'b0;
   logic                           valor_pronto;
   logic                           ocupado;
   logic                           pronto;
   logic                           overflow;
   logic signed [SW-1:0]           soma;
   logic        [LARGURA_CONT-1:0] contador;

   typedef struct {
      int soma;
      bit ov;
   } resultado_t;

   resultado_t esperado_q[$];
   resultado_t mon_e;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   somatorio_param #(
      .LARGURA      (LARGURA),
      .GUARDA       (GUARDA),
      .LARGURA_CONT (LARGURA_CONT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .inicio       (inicio),
      .quantidade   (quantidade),
      .valor        (valor),
      .valor_valido (valor_valido),
      .valor_pronto (valor_pronto),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .overflow     (overflow),
      .soma         (soma),
      .contador     (contador)
   );

   task automatic check(input string nome, input longint obtido, input longint requerido);
      checks++;
      if (obtido != requerido) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, obtido, requerido, $time);
      end
   endtask

   // Reference: exact integer sum, range test for overflow, then wrap or clamp
   function automatic resultado_t modelo(input int vals[$]);
      resultado_t r;
      int t;
      r.soma = 0;
      r.ov   = 1'b0;
      foreach (vals[k]) begin
         t = r.soma + vals[k];
         if (t > SMAX || t < SMIN) begin
            r.ov = 1'b1;
`ifdef SOMATORIO_SAT_EN
            t = (t > SMAX) ? SMAX : SMIN;
`else
            t = ((t - SMIN) % MODULO + MODULO) % MODULO + SMIN;
`endif
         end
         r.soma = t;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (!reset && pronto) begin
         if (esperado_q.size() == 0) begin
            check("pronto_unexpected", 1, 0);
         end else begin
            mon_e = esperado_q.pop_front();
            check("soma", int'(soma), mon_e.soma);
            check("overflow", overflow, mon_e.ov);
         end
      end
   end

   task automatic executa(input int vals[$], input int gap_pct);
      int q;
      int aceitos;
      int orcamento;
      bit acc;
      resultado_t e;
      q         = vals.size();
      aceitos   = 0;
      orcamento = 0;
      e         = modelo(vals);
      esperado_q.push_back(e);
      @(posedge clk); #1;
      inicio     = 1'b1;
      quantidade = LARGURA_CONT'(q);
      @(posedge clk); #1;
      inicio = 1'b0;
      while (aceitos < q && orcamento < 400) begin
         valor        = LARGURA'(vals[aceitos]);
         valor_valido = ($urandom_range(99) >= gap_pct);
         inicio       = 1'($urandom_range(1));
         quantidade   = LARGURA_CONT'($urandom);
         @(negedge clk);
         check("contador", contador, q - aceitos);
         check("valor_pronto", valor_pronto, 1);
         check("ocupado", ocupado, 1);
         acc = valor_valido && valor_pronto;
         @(posedge clk); #1;
         if (acc) aceitos++;
         orcamento++;
      end
      if (aceitos < q) check("accept_timeout", aceitos, q);
      inicio       = 1'b0;
      valor_valido = 1'b0;
      @(negedge clk);
      check("pronto_latency", pronto, 1);
      check("contador_fim", contador, 0);
      check("valor_pronto_fim", valor_pronto, 0);
      @(negedge clk);
      check("pronto_width", pronto, 0);
      check("ocupado_idle", ocupado, 0);
      check("soma_held", int'(soma), e.soma);
      check("overflow_held", overflow, e.ov);
   endtask

   initial begin
      int v[$];
      int n;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_soma", soma, 0);
      check("rst_contador", contador, 0);
      check("rst_overflow", overflow, 0);
      check("rst_pronto", pronto, 0);
      check("rst_ocupado", ocupado, 0);
      check("rst_valor_pronto", valor_pronto, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      v = {5, 7, -2};      executa(v, 0);
      v = {20, 20};        executa(v, 0);
      v = {-32, -1};       executa(v, 0);
      v = {1, 1, 1, 1};    executa(v, 50);
      v.delete();          executa(v, 0);
      v = {31, 31, -32, -32, -32, 5};  executa(v, 30);

      for (int op = 0; op < 25; op++) begin
         v.delete();
         n = ($urandom_range(9) == 0) ? 63 : int'($urandom_range(12));
         for (int k = 0; k < n; k++) v.push_back(int'($urandom_range(63)) - 32);
         executa(v, int'($urandom_range(60)));
      end

      // Reset in the middle of an operation aborts it without a pronto pulse
      @(posedge clk); #1;
      inicio     = 1'b1;
      quantidade = LARGURA_CONT'(5);
      @(posedge clk); #1;
      inicio       = 1'b0;
      valor        = LARGURA'(3);
      valor_valido = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset        = 1'b1;
      valor_valido = 1'b0;
      @(negedge clk);
      check("pre_reset_soma", int'(soma), 6);
      check("pre_reset_contador", contador, 3);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_soma", soma, 0);
      check("abort_contador", contador, 0);
      check("abort_overflow", overflow, 0);
      check("abort_ocupado", ocupado, 0);
      check("abort_valor_pronto", valor_pronto, 0);
      check("abort_pronto", pronto, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_idle_ocupado", ocupado, 0);

      v = {-5, 9};
      executa(v, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", esperado_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
